// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared constants and entry record for pipe_stage_reg.
// Used by pipe_stage_entry and pipe_stage_reg.
package pipe_stage_pkg;

   localparam int OCC_W      = 2;
   localparam int CTRL_W_DEF = 16;
   localparam int DATA_W_DEF = 128;

   localparam logic [CTRL_W_DEF-1:0] CTRL_CLR = '0;

   // Default-width record; entries re-declare it with their own widths.
   typedef struct packed {
      logic                  valid;
      logic [CTRL_W_DEF-1:0] ctrl;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;

   function automatic logic [OCC_W-1:0] occ_count(
      input logic a,
      input logic b
   );
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry: one valid+ctrl+data slot with load, drop, hold, clear.
// Priority: reset, clear, hold, load, drop; data survives clear and drop.
module pipe_stage_entry
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_hold,
   input  logic              i_load,
   input  logic              i_drop,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } ent_t;

   localparam logic [CTRL_W-1:0] W_CLR = CTRL_W'(CTRL_CLR);

   ent_t r_ent;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ent <= '0;
      end else if (i_clear) begin
         r_ent.valid <= 1'b0;
         r_ent.ctrl  <= W_CLR;
      end else if (!i_hold) begin
         if (i_load) begin
            r_ent.valid <= 1'b1;
            r_ent.ctrl  <= i_ctrl;
            r_ent.data  <= i_data;
         end else if (i_drop) begin
            r_ent.valid <= 1'b0;
            r_ent.ctrl  <= W_CLR;
         end
      end
   end

   assign o_valid = r_ent.valid;
   assign o_ctrl  = r_ent.ctrl;
   assign o_data  = r_ent.data;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic stage register with valid/ready, stall and flush.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg
   import pipe_stage_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   logic              w_m_valid;
   logic [CTRL_W-1:0] w_m_ctrl;
   logic [DATA_W-1:0] w_m_data;
   logic [CTRL_W-1:0] w_m_ctrl_d;
   logic [DATA_W-1:0] w_m_data_d;
   logic              w_m_load;
   logic              w_m_drop;
   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_s_occ;

   assign w_out_fire = w_m_valid & out_ready & ~stall;
   assign w_in_fire  = in_valid & w_in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
   logic              w_s_valid;
   logic [CTRL_W-1:0] w_s_ctrl;
   logic [DATA_W-1:0] w_s_data;
   logic              w_s_load;
   logic              w_s_drop;

   // Ready looks only at the skid slot, so out_ready never reaches in_ready.
   assign w_in_ready = ~stall & ~w_s_valid;

   assign w_m_load = (w_in_fire & (~w_m_valid | w_out_fire))
                   | (w_out_fire & w_s_valid);
   assign w_m_drop = w_out_fire & ~w_s_valid & ~w_in_fire;
   assign w_s_load = w_in_fire & w_m_valid & ~w_out_fire;
   assign w_s_drop = w_out_fire & w_s_valid;

   // A valid skid entry is always older than any beat being accepted.
   assign w_m_ctrl_d = w_s_valid ? w_s_ctrl : in_ctrl;
   assign w_m_data_d = w_s_valid ? w_s_data : in_data;

   pipe_stage_entry #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_s (
      .clk     (clk),
      .rst     (rst),
      .i_clear (flush),
      .i_hold  (stall),
      .i_load  (w_s_load),
      .i_drop  (w_s_drop),
      .i_ctrl  (in_ctrl),
      .i_data  (in_data),
      .o_valid (w_s_valid),
      .o_ctrl  (w_s_ctrl),
      .o_data  (w_s_data)
   );

   assign w_s_occ = w_s_valid;
`else
   assign w_in_ready = ~stall & (~w_m_valid | out_ready);

   assign w_m_load   = w_in_fire;
   assign w_m_drop   = w_out_fire & ~w_in_fire;
   assign w_m_ctrl_d = in_ctrl;
   assign w_m_data_d = in_data;
   assign w_s_occ    = 1'b0;
`endif

   pipe_stage_entry #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_m (
      .clk     (clk),
      .rst     (rst),
      .i_clear (flush),
      .i_hold  (stall),
      .i_load  (w_m_load),
      .i_drop  (w_m_drop),
      .i_ctrl  (w_m_ctrl_d),
      .i_data  (w_m_data_d),
      .o_valid (w_m_valid),
      .o_ctrl  (w_m_ctrl),
      .o_data  (w_m_data)
   );

   assign in_ready  = w_in_ready;
   assign out_valid = w_m_valid;
   assign out_ctrl  = w_m_ctrl & {CTRL_W{w_m_valid}};
   assign out_data  = w_m_data;
   assign occupancy = occ_count(w_m_valid, w_s_occ);

endmodule
